// File: rtl/parallel_adder4_pkg.sv
// Shared constants, types and lane-extension helper for the four-lane reduction adder.
// Signedness is selected at build time by PARALLEL_ADDER4_SIGNED_EN.
package parallel_adder4_pkg;

  localparam int unsigned LANES       = 4;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned SETTLE_LOAD = 2;
  localparam int unsigned RESET_CNT   = 3;
  localparam int unsigned CNT_W       = 2;

`ifdef PARALLEL_ADDER4_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef logic [DATA_W-1:0] lane_t;
  typedef logic [DATA_W:0]   pair_t;
  typedef logic [DATA_W+1:0] total_t;

  // Bit prepended when widening an operand by one: sign copy or zero.
  function automatic logic ext_bit(input logic msb);
    return msb & SIGNED_EN;
  endfunction

endpackage

// File: rtl/pa4_pair_add.sv
// Registered two-input adder; the result is one bit wider than the operands.
module pa4_pair_add
  import parallel_adder4_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   y
);

  logic [W:0] a_x;
  logic [W:0] b_x;

  assign a_x = {ext_bit(a[W-1]), a};
  assign b_x = {ext_bit(b[W-1]), b};

  // Register the widened sum; the extra bit absorbs the carry so no overflow occurs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) y <= '0;
    else       y <= a_x + b_x;
  end

endmodule

// File: rtl/parallel_adder4.sv
// Pipelined four-lane reduction adder with a settle counter that flags when
// sum matches the value currently on vector.
// Build option: PARALLEL_ADDER4_SIGNED_EN treats lanes as two's complement.
module parallel_adder4
  import parallel_adder4_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [LANES*WIDTH-1:0] vector,
  output logic [WIDTH+1:0]       sum,
  output logic                   finished
);

  logic [LANES*WIDTH-1:0] vec_q;
  logic [WIDTH:0]         p0;
  logic [WIDTH:0]         p1;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   chg;

  // Input register: stage 0 of the tree.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) vec_q <= '0;
    else       vec_q <= vector;
  end

  assign chg = (vector != vec_q);

  // Settle counter next state: a change reloads, otherwise count down to zero.
  always_comb begin
    cnt_nxt = cnt;
    if (chg)                 cnt_nxt = CNT_W'(SETTLE_LOAD);
    else if (cnt != '0)      cnt_nxt = cnt - CNT_W'(1);
  end

  // Settle counter register; reset value keeps finished low for three edges.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) cnt <= CNT_W'(RESET_CNT);
    else       cnt <= cnt_nxt;
  end

  assign finished = (cnt == '0);

  pa4_pair_add #(.W(WIDTH)) u_pair0 (
    .Clock (Clock),
    .Reset (Reset),
    .a     (vec_q[0*WIDTH +: WIDTH]),
    .b     (vec_q[1*WIDTH +: WIDTH]),
    .y     (p0)
  );

  pa4_pair_add #(.W(WIDTH)) u_pair1 (
    .Clock (Clock),
    .Reset (Reset),
    .a     (vec_q[2*WIDTH +: WIDTH]),
    .b     (vec_q[3*WIDTH +: WIDTH]),
    .y     (p1)
  );

  pa4_pair_add #(.W(WIDTH+1)) u_final (
    .Clock (Clock),
    .Reset (Reset),
    .a     (p0),
    .b     (p1),
    .y     (sum)
  );

endmodule

// File: tb/tb_parallel_adder4.sv
// Scoreboard bench for parallel_adder4: sampled inputs feed a reference model,
// a negedge monitor compares sum and finished every cycle.
module tb_parallel_adder4;

  localparam int unsigned W = 32;

  logic             Clock = 1'b0;
  logic             Reset;
  logic [4*W-1:0]   vector;
  logic [W+1:0]     sum;
  logic             finished;

  int checks = 0;
  int errors = 0;

  logic [W+1:0]   exp_q[$];
  logic [4*W-1:0] hist[$];
  int             edges;

  parallel_adder4 #(.WIDTH(W)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .vector   (vector),
    .sum      (sum),
    .finished (finished)
  );

  always #5 Clock = ~Clock;

  // Reference: arithmetic sum of the four lanes, truncated to W+2 bits.
  function automatic logic [W+1:0] model_sum(input logic [4*W-1:0] v);
    longint       acc;
    logic [W-1:0] lane;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      lane = v[W*i +: W];
`ifdef PARALLEL_ADDER4_SIGNED_EN
      acc += longint'($signed(lane));
`else
      acc += longint'({32'd0, lane});
`endif
    end
    return acc[W+1:0];
  endfunction

  // Output is settled once the last three sampled inputs agree and three edges passed reset.
  function automatic logic model_finished();
    if (edges < 3 || hist.size() < 3) return 1'b0;
    return (hist[0] == hist[1]) && (hist[1] == hist[2]);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Sampler: record what the DUT captures on each edge; reset empties the pipeline model.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      exp_q = {};
      exp_q.push_back('0);
      exp_q.push_back('0);
      hist = {};
      hist.push_back('0);
      edges = 0;
    end else begin
      exp_q.push_back(model_sum(vector));
      hist.push_back(vector);
      if (hist.size() > 3) void'(hist.pop_front());
      edges++;
    end
  end

  // Monitor: one comparison of sum and finished per elapsed edge.
  always @(negedge Clock) begin
    logic [W+1:0] e;
    if (!Reset && exp_q.size() > 2) begin
      e = exp_q.pop_front();
      chk("sb_sum", 64'(sum), 64'(e));
      chk("sb_finished", 64'(finished), 64'(model_finished()));
    end
  end

  function automatic logic [4*W-1:0] pack(input logic [W-1:0] l3, input logic [W-1:0] l2,
                                          input logic [W-1:0] l1, input logic [W-1:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  // Apply vector, then check finished low on two edges and the settled sum on the third.
  task automatic settle_check(input string name, input logic [4*W-1:0] v, input logic [W+1:0] exp);
    @(negedge Clock);
    vector = v;
    @(negedge Clock);
    chk({name, "_fin_e1"}, 64'(finished), 64'd0);
    @(negedge Clock);
    chk({name, "_fin_e2"}, 64'(finished), 64'd0);
    @(negedge Clock);
    chk({name, "_fin_e3"}, 64'(finished), 64'd1);
    chk({name, "_sum"}, 64'(sum), 64'(exp));
  endtask

  initial begin
    Reset  = 1'b1;
    vector = '0;
    repeat (2) @(negedge Clock);
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_fin", 64'(finished), 64'd0);

    // Release with constant zero input: finished at the third edge.
    Reset = 1'b0;
    @(negedge Clock);
    chk("rel_fin_e1", 64'(finished), 64'd0);
    @(negedge Clock);
    chk("rel_fin_e2", 64'(finished), 64'd0);
    @(negedge Clock);
    chk("rel_fin_e3", 64'(finished), 64'd1);
    chk("rel_sum", 64'(sum), 64'd0);

    settle_check("lanes_24_8_8_8", pack(32'd24, 32'd8, 32'd8, 32'd8), 34'd48);
    settle_check("all_ones", pack('1, '1, '1, '1), 34'h3_FFFF_FFFC);
`ifdef PARALLEL_ADDER4_SIGNED_EN
    settle_check("neg8_mix", pack(32'd24, 32'd8, 32'd8, 32'hFFFF_FFF8), 34'h0_0000_0020);
`else
    settle_check("neg8_mix", pack(32'd24, 32'd8, 32'd8, 32'hFFFF_FFF8), 34'h1_0000_0020);
`endif

    // Back-to-back change: the second change restarts the settle count.
    @(negedge Clock);
    vector = pack(32'd1, 32'd1, 32'd1, 32'd1);
    @(negedge Clock);
    chk("b2b_fin_a", 64'(finished), 64'd0);
    vector = pack(32'd2, 32'd2, 32'd2, 32'd2);
    @(negedge Clock);
    chk("b2b_fin_e1", 64'(finished), 64'd0);
    @(negedge Clock);
    chk("b2b_fin_e2", 64'(finished), 64'd0);
    @(negedge Clock);
    chk("b2b_fin_e3", 64'(finished), 64'd1);
    chk("b2b_sum", 64'(sum), 64'd8);

    // Asynchronous reset mid-settle takes effect without an edge.
    @(negedge Clock);
    vector = pack(32'd3, 32'd3, 32'd3, 32'd3);
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rst_sum", 64'(sum), 64'd0);
    chk("async_rst_fin", 64'(finished), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("post_rst_fin_e1", 64'(finished), 64'd0);
    @(negedge Clock);
    chk("post_rst_fin_e2", 64'(finished), 64'd0);
    @(negedge Clock);
    chk("post_rst_fin_e3", 64'(finished), 64'd1);
    chk("post_rst_sum", 64'(sum), 64'd12);

    // Random traffic: mix of holds and fresh vectors, checked by the scoreboard.
    for (int n = 0; n < 300; n++) begin
      @(negedge Clock);
      if ($urandom_range(0, 2) == 0)
        vector = pack($urandom, $urandom, $urandom, $urandom);
      else if ($urandom_range(0, 3) == 0)
        vector = pack(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                      W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    end
    repeat (5) @(negedge Clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parallel_adder4.md
# parallel_adder4

Pipelined four-lane unsigned reduction adder. It sums four WIDTH-bit words packed into one input bus and produces a WIDTH+2-bit total through a registered two-level adder tree. A `finished` flag marks when `sum` reflects the current input. The block is the reduction stage behind the matrix-multiply dot-product lanes.

## Interface
- `WIDTH`, default 32: width of each lane word.
- `Clock`  in  1: single clock; all state updates on the rising edge.
- `Reset`  in  1: reset is asynchronous and active-high.
- `vector`  in  4*WIDTH: four packed lane words; lane i = `vector[WIDTH*i +: WIDTH]`, lane 0 in the LSBs.
- `sum`  out  WIDTH+2: registered sum of the four lanes.
- `finished`  out  1: high when `sum` corresponds to the value currently held on `vector`.

## Operation
- Stage 0, input register: `vec_q <= vector` on every edge.
- Stage 1, pair sums:
  - `p0 <= lane0 + lane1` and `p1 <= lane2 + lane3`, each WIDTH+1 bits.
  - Operands are zero-extended.
- Stage 2, final sum: `sum <= p0 + p1`, WIDTH+2 bits. The sum cannot overflow.
- Change detect: `chg = (vector != vec_q)`, combinational.
- Settle counter `cnt`, 2 bits:
  - If `chg`, load 2.
  - Else if `cnt != 0`, decrement.
  - Else hold.
- `finished = (cnt == 0)`, decoded directly from the counter register.
- No start or valid handshake. The block free-runs, and any change on `vector` restarts the settle count.
- Reset, asynchronous: `vec_q`, `p0`, `p1` and `sum` go to 0 and `cnt` goes to 3, so `finished` = 0. All are restored immediately on assertion, regardless of the clock.
- Reset mid-operation abandons any in-flight sum. After release, operation restarts exactly as from power-up.

## Timing
- Latency is 3 rising edges from `vector` becoming stable to the matching `sum`.
- `finished` rises on the same edge that `sum` takes the matching value.
- On a change at edge E0 while `finished` = 1:
  - `finished` falls at E1.
  - `sum` is updated and `finished` rises at E3.
- Until then `sum` holds stale or partial values and must not be consumed.
- Back-to-back changes every cycle keep `finished` low. Intermediate `sum` values still stream out, each 3 edges after its input.
- After reset release, `finished` rises at the third edge, even when `vector` is constant.
- A new change on the same edge the counter reaches 1 or 0 reloads 2; the load wins over the decrement.

## Configuration
- Macro `PARALLEL_ADDER4_SIGNED_EN`.
- Defined:
  - Lanes are two's complement and sign-extended at every stage.
  - `sum` is a signed WIDTH+2-bit result.
- Undefined (the default): unsigned, zero-extended as above.
- Timing and the `finished` behaviour are identical in both modes.

## Structure
- Shared package `parallel_adder4_pkg` holds:
  - `LANES` = 4.
  - `SETTLE_LOAD` = 2 and `RESET_CNT` = 3.
  - Typedefs for the lane word, the pair sum (WIDTH+1) and the total (WIDTH+2).
  - The extension function, signed or unsigned depending on the macro.
- One sub-module, `pa4_pair_add`: a registered two-input adder with asynchronous reset and output width one bit wider than its inputs.
  - Instantiated twice for stage 1 and once for stage 2.
- Top level: the input register, the change detector and the settle counter.

## Test plan
- Reset with `vector` = 0 → `sum` = 0 and `finished` = 0 during reset; `finished` = 1 at the third edge after release.
- Lanes {24, 8, 8, 8}, i.e. `vector` = 128'h00000018_00000008_00000008_00000008 → `finished` low for 2 edges, then `sum` = 34'd48 with `finished` = 1 at the third edge.
- All lanes 32'hFFFFFFFF, unsigned → `sum` = 34'h3_FFFF_FFFC with `finished` = 1 after 3 edges (no overflow).
- Change `vector` from {1,1,1,1} to {2,2,2,2} one edge after the first change:
  - `finished` stays low.
  - `sum` = 8 appears 3 edges after the second change.
  - The transient 4 may appear with `finished` low.
- Assert `Reset` asynchronously mid-settle → `sum` = 0 and `finished` = 0 at once, without waiting for an edge; after release, the correct sum appears 3 edges later.
- With `PARALLEL_ADDER4_SIGNED_EN` defined: lanes {0xFFFFFFF8, 8, 8, 24} → `sum` = 34'h0_0000_0020 (signed 32). Unsigned build with the same lanes → `sum` = 34'h1_0000_0020.
